expand_mpc_challenge_unit: RTL and testbench

Expands the first-round commitment hash h1 into the MPC challenge vectors r and eps for the SDitH signer. It streams h1 from an external word memory into the shared XOF/hash engine and collects the squeezed output as GF(2^32) elements into two internal row memories. The signer's MPC-evaluation stage then reads those memories. The block sits between the h1 storage and the hash_mem_interface wrapper.

---
 rtl/expand_mpc_challenge_unit_if.sv | 34 +++
 rtl/expand_mpc_challenge_unit.sv | 170 +++++++++++++++++
 tb/tb_expand_mpc_challenge_unit.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/expand_mpc_challenge_unit_if.sv
// Hash-engine bus between the challenge expander and the shared XOF/hash
// wrapper. Signal names carry the expander's point of view (o_ = driven by
// the expander, i_ = driven by the hash engine).
//   master : expander side (starts the hash, consumes squeezed words)
//   slave  : hash-engine side (reads the input words, emits output words)
interface expand_mpc_challenge_unit_if #(
  parameter int unsigned AW = 3
);
  logic [31:0]   o_hash_data_in;
  logic [AW-1:0] i_hash_addr;
  logic          i_hash_rd_en;
  logic [31:0]   i_hash_data_out;
  logic          i_hash_data_out_valid;
  logic          o_hash_data_out_ready;
  logic [31:0]   o_hash_input_length;
  logic [31:0]   o_hash_output_length;
  logic          o_hash_start;
  logic          o_hash_force_done;
  logic          i_hash_force_done_ack;

  modport master (
    output o_hash_data_in, o_hash_data_out_ready, o_hash_input_length,
           o_hash_output_length, o_hash_start, o_hash_force_done,
    input  i_hash_addr, i_hash_rd_en, i_hash_data_out, i_hash_data_out_valid,
           i_hash_force_done_ack
  );

  modport slave (
    input  o_hash_data_in, o_hash_data_out_ready, o_hash_input_length,
           o_hash_output_length, o_hash_start, o_hash_force_done,
    output i_hash_addr, i_hash_rd_en, i_hash_data_out, i_hash_data_out_valid,
           i_hash_force_done_ack
  );
endinterface

// File: rtl/expand_mpc_challenge_unit.sv
// Expands h1 into the MPC challenge vectors r and eps. h1 is streamed from
// an external word memory straight into the hash engine; the squeezed words
// are packed T per row into the r memory (first N_WORDS) and then the eps
// memory (next N_WORDS).
// Ports:
//   i_clk, i_rst (sync, active-low)      clock / reset
//   i_start / o_done                      one-cycle start / completion pulses
//   o_h1_rd, o_h1_addr, i_h1              h1 word memory read port
//   i_r_rd, i_r_addr, o_r                 r row read port (registered)
//   i_eps_rd, i_eps_addr, o_eps           eps row read port (registered)
//   hash_bus                              hash-engine bus (master side)
module expand_mpc_challenge_unit #(
  parameter string PARAMETER_SET = "L1",
  localparam int unsigned LAMBDA   = (PARAMETER_SET == "L5") ? 256 :
                                     ((PARAMETER_SET == "L3") ? 192 : 128),
  localparam int unsigned D_SPLIT  = (PARAMETER_SET == "L1") ? 1 : 2,
  localparam int unsigned TAU      = 17,
  localparam int unsigned T        = (PARAMETER_SET == "L5") ? 4 : 3,
  localparam int unsigned ROWS     = TAU * D_SPLIT,
  localparam int unsigned H1_WORDS = 2 * LAMBDA / 32,
  localparam int unsigned N_WORDS  = ROWS * T,
  localparam int unsigned H1_AW    = $clog2(H1_WORDS),
  localparam int unsigned ROW_AW   = $clog2(ROWS)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  output logic                    o_done,
  output logic                    o_h1_rd,
  output logic [H1_AW-1:0]        o_h1_addr,
  input  logic [31:0]             i_h1,
  output logic [T*32-1:0]         o_r,
  input  logic [ROW_AW-1:0]       i_r_addr,
  input  logic                    i_r_rd,
  output logic [T*32-1:0]         o_eps,
  input  logic [ROW_AW-1:0]       i_eps_addr,
  input  logic                    i_eps_rd,
  expand_mpc_challenge_unit_if.master hash_bus
);

  localparam int unsigned LANE_AW = $clog2(T);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_COLLECT, S_FORCE, S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [LANE_AW-1:0]      lane_q, lane_d;
  logic [ROW_AW-1:0]       row_q, row_d;
  logic                    eps_sel_q, eps_sel_d;
  logic [T-1:0][31:0]      fill_q, fill_d;
  logic                    row_we;
  logic                    accept;
  logic                    start_q, ready_q, force_q, done_q;
  logic [T*32-1:0]         o_r_q, o_eps_q;

  logic [T-1:0][31:0]      r_mem   [ROWS];
  logic [T-1:0][31:0]      eps_mem [ROWS];

  // h1 is fed to the hash engine without buffering; the engine absorbs the
  // one-cycle memory latency itself.
  assign o_h1_addr               = H1_AW'(hash_bus.i_hash_addr);
  assign o_h1_rd                 = hash_bus.i_hash_rd_en;
  assign hash_bus.o_hash_data_in = i_h1;

  assign hash_bus.o_hash_input_length  = 32'(2 * LAMBDA);
  assign hash_bus.o_hash_output_length = 32'(2 * N_WORDS * 32);

  assign hash_bus.o_hash_start          = start_q;
  assign hash_bus.o_hash_data_out_ready = ready_q;
  assign hash_bus.o_hash_force_done     = force_q;
  assign o_done                         = done_q;
  assign o_r                            = o_r_q;
  assign o_eps                          = o_eps_q;

  assign accept = ready_q & hash_bus.i_hash_data_out_valid;

  // Next-state and word packing: lane -> row -> r/eps bank.
  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    row_d     = row_q;
    eps_sel_d = eps_sel_q;
    fill_d    = fill_q;
    row_we    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) state_d = S_START;
      end
      S_START: begin
        lane_d    = '0;
        row_d     = '0;
        eps_sel_d = 1'b0;
        state_d   = S_COLLECT;
      end
      S_COLLECT: begin
        if (accept) begin
          fill_d[lane_q] = hash_bus.i_hash_data_out;
          if (lane_q == LANE_AW'(T - 1)) begin
            row_we = 1'b1;
            lane_d = '0;
            if (row_q == ROW_AW'(ROWS - 1)) begin
              row_d     = '0;
              eps_sel_d = 1'b1;
              if (eps_sel_q) state_d = S_FORCE;
            end else begin
              row_d = row_q + ROW_AW'(1);
            end
          end else begin
            lane_d = lane_q + LANE_AW'(1);
          end
        end
      end
      S_FORCE: begin
        if (hash_bus.i_hash_force_done_ack) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and registered control outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q   <= S_IDLE;
      lane_q    <= '0;
      row_q     <= '0;
      eps_sel_q <= 1'b0;
      fill_q    <= '0;
      start_q   <= 1'b0;
      ready_q   <= 1'b0;
      force_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      row_q     <= row_d;
      eps_sel_q <= eps_sel_d;
      fill_q    <= fill_d;
      start_q   <= (state_d == S_START);
      ready_q   <= (state_d == S_COLLECT);
      force_q   <= (state_d == S_FORCE);
      done_q    <= (state_d == S_DONE);
    end
  end

  // Row memories keep their contents across reset.
  always_ff @(posedge i_clk) begin
    if (i_rst && row_we) begin
      if (eps_sel_q) eps_mem[row_q] <= fill_d;
      else           r_mem[row_q]   <= fill_d;
    end
  end

  // Registered read ports; out-of-range addresses leave the output unchanged.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_r_q   <= '0;
      o_eps_q <= '0;
    end else begin
      if (i_r_rd && (32'(i_r_addr) < ROWS))     o_r_q   <= r_mem[i_r_addr];
      if (i_eps_rd && (32'(i_eps_addr) < ROWS)) o_eps_q <= eps_mem[i_eps_addr];
    end
  end

endmodule

// File: tb/tb_expand_mpc_challenge_unit.sv
// Bench for the MPC challenge expander: an L1 instance driven by a hash stub
// with programmable words and random valid gaps, and an L5 instance driven by
// a gap-free counting stub. Expected rows come from the word-index rule
// (r row k lane t = word k*T+t, eps row k lane t = word N_WORDS+k*T+t).
module tb_expand_mpc_challenge_unit;

  localparam int T1 = 3, ROWS1 = 17, N1 = 51, NW1 = 102;
  localparam int T5 = 4, ROWS5 = 34, N5 = 136, NW5 = 272;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // L1 instance
  logic         start1 = 1'b0, done1, h1_rd1;
  logic [2:0]   h1_addr1;
  logic [31:0]  h1_1 = '0;
  logic [95:0]  o_r1, o_eps1;
  logic [4:0]   r_addr1 = '0, eps_addr1 = '0;
  logic         r_rd1 = 1'b0, eps_rd1 = 1'b0;
  expand_mpc_challenge_unit_if #(.AW(3)) hb1 ();

  expand_mpc_challenge_unit #(.PARAMETER_SET("L1")) u1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .o_done(done1),
    .o_h1_rd(h1_rd1), .o_h1_addr(h1_addr1), .i_h1(h1_1),
    .o_r(o_r1), .i_r_addr(r_addr1), .i_r_rd(r_rd1),
    .o_eps(o_eps1), .i_eps_addr(eps_addr1), .i_eps_rd(eps_rd1),
    .hash_bus(hb1)
  );

  // L5 instance
  logic         start5 = 1'b0, done5, h1_rd5;
  logic [3:0]   h1_addr5;
  logic [31:0]  h1_5 = '0;
  logic [127:0] o_r5, o_eps5;
  logic [5:0]   r_addr5 = '0, eps_addr5 = '0;
  logic         r_rd5 = 1'b0, eps_rd5 = 1'b0;
  expand_mpc_challenge_unit_if #(.AW(4)) hb5 ();

  expand_mpc_challenge_unit #(.PARAMETER_SET("L5")) u5 (
    .i_clk(clk), .i_rst(rst), .i_start(start5), .o_done(done5),
    .o_h1_rd(h1_rd5), .o_h1_addr(h1_addr5), .i_h1(h1_5),
    .o_r(o_r5), .i_r_addr(r_addr5), .i_r_rd(r_rd5),
    .o_eps(o_eps5), .i_eps_addr(eps_addr5), .i_eps_rd(eps_rd5),
    .hash_bus(hb5)
  );

  // L1 hash stub: emits words1[] in order, holding valid until accepted,
  // with 0..gap_max idle cycles between words.
  logic [31:0] words1 [NW1];
  int unsigned gap_max = 0;
  int          idx1 = 0, gap1 = 0;
  int unsigned g1;
  logic        act1 = 1'b0, v1 = 1'b0, ack1 = 1'b0;
  logic [31:0] d1 = '0;

  always @(posedge clk) begin
    if (!rst) begin
      act1 <= 1'b0; v1 <= 1'b0; idx1 <= 0; gap1 <= 0; ack1 <= 1'b0;
    end else begin
      ack1 <= hb1.o_hash_force_done && !ack1;
      if (hb1.o_hash_start) begin
        act1 <= 1'b1; v1 <= 1'b0; idx1 <= 0;
        gap1 <= int'($urandom_range(0, gap_max));
      end else if (act1) begin
        if (v1 && hb1.o_hash_data_out_ready) begin
          g1 = $urandom_range(0, gap_max);
          idx1 <= idx1 + 1;
          if (idx1 + 1 == NW1) begin
            v1 <= 1'b0; act1 <= 1'b0;
          end else if (g1 == 0) begin
            d1 <= words1[idx1 + 1];
          end else begin
            v1 <= 1'b0; gap1 <= int'(g1) - 1;
          end
        end else if (!v1) begin
          if (gap1 == 0) begin
            v1 <= 1'b1; d1 <= words1[idx1];
          end else begin
            gap1 <= gap1 - 1;
          end
        end
      end
    end
  end

  assign hb1.i_hash_data_out       = d1;
  assign hb1.i_hash_data_out_valid = v1;
  assign hb1.i_hash_force_done_ack = ack1;

  // L5 hash stub: gap-free counting words 0,1,2,...
  int   idx5 = 0;
  logic v5 = 1'b0, ack5 = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      v5 <= 1'b0; idx5 <= 0; ack5 <= 1'b0;
    end else begin
      ack5 <= hb5.o_hash_force_done && !ack5;
      if (hb5.o_hash_start) begin
        v5 <= 1'b1; idx5 <= 0;
      end else if (v5 && hb5.o_hash_data_out_ready) begin
        if (idx5 + 1 == NW5) v5 <= 1'b0;
        idx5 <= idx5 + 1;
      end
    end
  end

  assign hb5.i_hash_data_out       = 32'(idx5);
  assign hb5.i_hash_data_out_valid = v5;
  assign hb5.i_hash_force_done_ack = ack5;

  int done_cnt1 = 0;
  always @(posedge clk) if (done1) done_cnt1 <= done_cnt1 + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [127:0] exp_row1(input bit eps, input int k);
    logic [127:0] v;
    v = '0;
    for (int t = 0; t < T1; t++) v[32*t +: 32] = words1[(eps ? N1 : 0) + k*T1 + t];
    return v;
  endfunction

  function automatic logic [127:0] exp_row5(input bit eps, input int k);
    logic [127:0] v;
    v = '0;
    for (int t = 0; t < T5; t++) v[32*t +: 32] = 32'((eps ? N5 : 0) + k*T5 + t);
    return v;
  endfunction

  task automatic read1(input int rk, input int ek);
    @(negedge clk);
    r_addr1 = 5'(rk); eps_addr1 = 5'(ek); r_rd1 = 1'b1; eps_rd1 = 1'b1;
    @(posedge clk); #1;
    r_rd1 = 1'b0; eps_rd1 = 1'b0;
  endtask

  task automatic read5(input int rk, input int ek);
    @(negedge clk);
    r_addr5 = 6'(rk); eps_addr5 = 6'(ek); r_rd5 = 1'b1; eps_rd5 = 1'b1;
    @(posedge clk); #1;
    r_rd5 = 1'b0; eps_rd5 = 1'b0;
  endtask

  task automatic wait_done1(input string tag, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk); #1;
      if (done1) begin ok = 1'b1; break; end
    end
    check({tag, "_done_seen"}, 128'(ok), 128'(1));
  endtask

  // One complete L1 expansion; optionally re-pulses i_start mid-collect.
  task automatic run1(input string tag, input bit repulse);
    int snap;
    bit ok;
    snap = done_cnt1;
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    if (repulse) begin
      for (int c = 0; c < 2000 && idx1 < 30; c++) @(negedge clk);
      start1 = 1'b1;
      @(negedge clk) start1 = 1'b0;
    end
    wait_done1(tag, ok);
    if (ok) begin
      for (int k = 0; k < ROWS1; k++) begin
        read1(k, k);
        check($sformatf("%s_r%0d", tag, k), 128'(o_r1), exp_row1(1'b0, k));
        check($sformatf("%s_eps%0d", tag, k), 128'(o_eps1), exp_row1(1'b1, k));
      end
      check({tag, "_ready_low"}, 128'(hb1.o_hash_data_out_ready), 128'(0));
    end
    repeat (4) @(negedge clk);
    check({tag, "_one_done"}, 128'(done_cnt1 - snap), 128'(1));
  endtask

  initial begin
    logic [2:0] a;
    bit ok5;
    hb1.i_hash_addr = '0; hb1.i_hash_rd_en = 1'b0;
    hb5.i_hash_addr = '0; hb5.i_hash_rd_en = 1'b0;
    for (int i = 0; i < NW1; i++) words1[i] = 32'(i);

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_done",  128'(done1), 128'(0));
    check("rst_hstart", 128'(hb1.o_hash_start), 128'(0));
    check("rst_ready", 128'(hb1.o_hash_data_out_ready), 128'(0));
    check("rst_force", 128'(hb1.o_hash_force_done), 128'(0));
    check("rst_r",     128'(o_r1), 128'(0));
    check("rst_eps",   128'(o_eps1), 128'(0));
    @(negedge clk) rst = 1'b1;

    // Length constants
    check("l1_in_len",  128'(hb1.o_hash_input_length), 128'(256));
    check("l1_out_len", 128'(hb1.o_hash_output_length), 128'(3264));
    check("l5_in_len",  128'(hb5.o_hash_input_length), 128'(512));
    check("l5_out_len", 128'(hb5.o_hash_output_length), 128'(8704));

    // h1 passthrough
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = 3'($urandom_range(0, 7));
      hb1.i_hash_addr = a; hb1.i_hash_rd_en = i[0]; h1_1 = $urandom;
      #1;
      check("pt_addr", 128'(h1_addr1), 128'(a));
      check("pt_rd",   128'(h1_rd1), 128'(i[0]));
      check("pt_data", 128'(hb1.o_hash_data_in), 128'(h1_1));
    end
    @(negedge clk) hb1.i_hash_rd_en = 1'b0;

    // Counting words, no gaps
    gap_max = 0;
    run1("cnt", 1'b0);
    read1(0, 0);
    check("cnt_r_row0",  128'(o_r1),   128'({32'd2, 32'd1, 32'd0}));
    check("cnt_eps_row0", 128'(o_eps1), 128'({32'd53, 32'd52, 32'd51}));
    read1(16, 16);
    check("cnt_r_row16",  128'(o_r1),   128'({32'd50, 32'd49, 32'd48}));
    check("cnt_eps_row16", 128'(o_eps1), 128'({32'd101, 32'd100, 32'd99}));

    // Random words, gap-free then the same words with gaps and a stray start
    for (int i = 0; i < NW1; i++) words1[i] = $urandom;
    run1("rnd_nogap", 1'b0);
    gap_max = 5;
    run1("rnd_gap", 1'b1);

    // Reset in mid-collect, then a fresh run
    for (int i = 0; i < NW1; i++) words1[i] = $urandom;
    gap_max = 2;
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    for (int c = 0; c < 2000 && idx1 < 40; c++) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_ready",  128'(hb1.o_hash_data_out_ready), 128'(0));
    check("mid_rst_done",   128'(done1), 128'(0));
    check("mid_rst_hstart", 128'(hb1.o_hash_start), 128'(0));
    check("mid_rst_force",  128'(hb1.o_hash_force_done), 128'(0));
    check("mid_rst_r",      128'(o_r1), 128'(0));
    check("mid_rst_eps",    128'(o_eps1), 128'(0));
    @(negedge clk) rst = 1'b1;
    run1("after_rst", 1'b0);

    // L5 counting run
    @(negedge clk) start5 = 1'b1;
    @(negedge clk) start5 = 1'b0;
    ok5 = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk); #1;
      if (done5) begin ok5 = 1'b1; break; end
    end
    check("l5_done_seen", 128'(ok5), 128'(1));
    read5(0, 0);
    check("l5_eps_row0", o_eps5, 128'({32'd139, 32'd138, 32'd137, 32'd136}));
    check("l5_r_row0",   o_r5, exp_row5(1'b0, 0));
    read5(33, 33);
    check("l5_r_row33",   o_r5, exp_row5(1'b0, 33));
    check("l5_eps_row33", o_eps5, exp_row5(1'b1, 33));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
